wb_queue_regfile: RTL and testbench
===================================

Name: wb_queue_regfile

Overview:
- Parametrised next-generation writeback stage for the LC3 core.
- Selects the result source (ALU / memory / PC) per instruction and buffers results in a DEPTH-entry in-order write queue with valid/ready handshake.
- Drains one entry per cycle into a NUM_REGS x DATA_W register file and updates the NZP condition codes at drain time.
- Provides two read ports for decode, plus a debug write port that has priority over the queue drain.

Parameters:
- DATA_W, 16, datapath width in bits
- NUM_REGS, 8, register count (power of 2, ≥2); AW = $clog2(NUM_REGS)
- DEPTH, 2, write-queue entries (power of 2, ≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  result offered
- in_ready  out  1  queue can accept
- in_sel  in  2  source: 0 aluout, 1 memout, 2 pcout, 3 constant zero
- aluout  in  DATA_W  ALU result
- memout  in  DATA_W  memory result
- pcout  in  DATA_W  PC-relative result
- in_dr  in  AW  destination register
- in_setcc  in  1  entry updates PSR when drained
- sr1  in  AW  read address 1
- sr2  in  AW  read address 2
- VSR1  out  DATA_W  read data 1
- VSR2  out  DATA_W  read data 2
- rd_pending  out  2  bit i set when sr(i+1) matches any valid queue entry
- dbg_wr_en  in  1  debug write strobe
- dbg_wr_addr  in  AW  debug write register
- dbg_wr_data  in  DATA_W  debug write data
- psr  out  3  NZP flags {N,Z,P}
- q_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - queue empty, q_count=0, in_ready=1
  - all registers 0, psr=3'b000
  - rd_pending=0; VSR1/VSR2 read 0
- Enqueue:
  - occurs on a rising edge with in_valid && in_ready.
  - the entry captures {mux(in_sel) value, in_dr, in_setcc}; in_sel=3 stores 0.
- in_ready = (q_count < DEPTH). It has no combinational dependence on drain; a full queue refuses input even in a cycle where it drains.
- Drain:
  - each edge where the queue is non-empty and dbg_wr_en=0, the head entry is written to rf[dr] and popped.
  - if the entry's setcc=1, psr <= 100 (value[DATA_W-1]=1), 010 (value==0) or 001 (otherwise).
- Debug write:
  - dbg_wr_en=1 writes rf[dbg_wr_addr] and blocks the drain that cycle.
  - psr is unaffected.
  - a later drain to the same register overwrites the debug value.
- Simultaneous enqueue+drain: q_count unchanged; pointers wrap modulo DEPTH.
- Latency: accepted at edge N, written to the register file at edge N+1 at the earliest. Each cycle of debug-write priority adds one cycle.
- Reads are combinational from the register file (subject to bypass, below).
- rd_pending is always computed, regardless of bypass.
- Reset mid-operation discards all queued entries; the queued writes never reach the register file or psr.
- Registers are written only by drain or debug write; there is no other write path.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: VSR1/VSR2 return the youngest valid queue entry whose dr matches sr1/sr2; otherwise the register file value. A value is readable the cycle after acceptance.
- Undefined: VSR1/VSR2 read the register file only; decode must stall on rd_pending.
- The queue itself is identical in both builds.

Decomposition:
- Package wb_pkg:
  - wb_sel_e enum (WB_ALU=0, WB_MEM=1, WB_PC=2, WB_ZERO=3)
  - PSR constants PSR_N=3'b100, PSR_Z=3'b010, PSR_P=3'b001, PSR_RST=3'b000
  - parametrised function calc_nzp
- Sub-module wb_regfile (NUM_REGS, DATA_W): one write port, two asynchronous read ports, synchronous reset to zero.
- Queue storage, pointers, forwarding search and psr logic live in the top module.

Test Plan:
- Reset, then read all registers → VSR1/VSR2=0, psr=000, in_ready=1, q_count=0.
- Enqueue sel=0 aluout=16'h8000 dr=3 setcc=1 → next cycle rf[3]=16'h8000, psr=100; then sel=3 dr=4 setcc=1 → rf[4]=0, psr=010.
- DEPTH=2; hold dbg_wr_en=1 for 3 cycles while offering 3 results → q_count reaches 2 and in_ready=0; release → entries drain in order, one per cycle, and the 3rd result is accepted after the first drain.
- Enqueue memout=16'h0005 dr=1, then immediately sr1=1 → rd_pending[0]=1; with WB_BYPASS_EN VSR1=16'h0005 that cycle, without it VSR1 shows the old rf value until the drain.
- Two queued writes to dr=2 (16'h0011, then 16'h0022), debug write 16'h00FF to r2 concurrently → final rf[2]=16'h0022, psr=001; reset asserted with 2 entries queued → rf unchanged, q_count=0, psr=000.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - writeback source selects, NZP constants and flag helper
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC   = 2'd2,
        WB_ZERO = 2'd3
    } wb_sel_e;

    localparam logic [2:0] PSR_N   = 3'b100;
    localparam logic [2:0] PSR_Z   = 3'b010;
    localparam logic [2:0] PSR_P   = 3'b001;
    localparam logic [2:0] PSR_RST = 3'b000;

    // Caller zero-extends its value; width selects which bit acts as the sign.
    function automatic logic [2:0] calc_nzp(input logic [63:0] value, input int width);
        if (((value >> (width - 1)) & 64'd1) != 64'd0)
            return PSR_N;
        else if (value == 64'd0)
            return PSR_Z;
        return PSR_P;
    endfunction

endpackage

// File: rtl/wb_queue_regfile_if.sv
// rtl/wb_queue_regfile_if.sv - result offer bus into the writeback queue
interface wb_queue_regfile_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] memout;
    logic [DATA_W-1:0] pcout;
    logic [AW-1:0]     in_dr;
    logic              in_setcc;

    modport master (
        output in_valid, in_sel, aluout, memout, pcout, in_dr, in_setcc,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_sel, aluout, memout, pcout, in_dr, in_setcc,
        output in_ready
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - register file, one write port and two asynchronous read ports
module wb_regfile #(
    parameter  int NUM_REGS = 8,
    parameter  int DATA_W   = 16,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr1,
    input  logic [AW-1:0]     i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];
endmodule

// File: rtl/wb_queue_regfile.sv
// rtl/wb_queue_regfile.sv - writeback queue, drain and NZP update; WB_BYPASS_EN forwards queued results to reads
module wb_queue_regfile
    import wb_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    parameter  int DEPTH    = 2,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    wb_queue_regfile_if.slave wb,
    input  logic [AW-1:0]     sr1,
    input  logic [AW-1:0]     sr2,
    output logic [DATA_W-1:0] VSR1,
    output logic [DATA_W-1:0] VSR2,
    output logic [1:0]        rd_pending,
    input  logic              dbg_wr_en,
    input  logic [AW-1:0]     dbg_wr_addr,
    input  logic [DATA_W-1:0] dbg_wr_data,
    output logic [2:0]        psr,
    output logic [CW-1:0]     q_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_q_val [DEPTH];
    logic [AW-1:0]     r_q_dr  [DEPTH];
    logic [DEPTH-1:0]  r_q_cc;
    logic [DEPTH-1:0]  r_q_vld;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [2:0]        r_psr;

    logic [DATA_W-1:0] w_in_val;
    logic [DATA_W-1:0] w_rf_wdata;
    logic [DATA_W-1:0] w_rf_rd1;
    logic [DATA_W-1:0] w_rf_rd2;
    logic [AW-1:0]     w_rf_waddr;
    logic              w_ready;
    logic              w_enq;
    logic              w_drain;
    logic              w_rf_we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_in_val = '0;
        case (wb_sel_e'(wb.in_sel))
            WB_ALU:  w_in_val = wb.aluout;
            WB_MEM:  w_in_val = wb.memout;
            WB_PC:   w_in_val = wb.pcout;
            default: w_in_val = '0;
        endcase
    end

    // Readiness depends only on occupancy so a full queue never accepts, even while draining.
    assign w_ready     = (r_count < CW'(DEPTH));
    assign wb.in_ready = w_ready;
    assign w_enq       = wb.in_valid && w_ready;
    assign w_drain     = (r_count != '0) && !dbg_wr_en;

    assign w_rf_we    = dbg_wr_en || w_drain;
    assign w_rf_waddr = dbg_wr_en ? dbg_wr_addr : r_q_dr[r_rd_ptr];
    assign w_rf_wdata = dbg_wr_en ? dbg_wr_data : r_q_val[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_q_vld  <= '0;
            r_psr    <= PSR_RST;
        end else begin
            if (w_enq) begin
                r_q_val[r_wr_ptr] <= w_in_val;
                r_q_dr[r_wr_ptr]  <= wb.in_dr;
                r_q_cc[r_wr_ptr]  <= wb.in_setcc;
                r_q_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_drain) begin
                r_q_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= ptr_inc(r_rd_ptr);
                if (r_q_cc[r_rd_ptr])
                    r_psr <= calc_nzp(64'(r_q_val[r_rd_ptr]), DATA_W);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_drain);
        end
    end

    wb_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_rf_we),
        .i_waddr  (w_rf_waddr),
        .i_wdata  (w_rf_wdata),
        .i_raddr1 (sr1),
        .i_raddr2 (sr2),
        .o_rdata1 (w_rf_rd1),
        .o_rdata2 (w_rf_rd2)
    );

    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_q_vld[i] && (r_q_dr[i] == sr1)) rd_pending[0] = 1'b1;
            if (r_q_vld[i] && (r_q_dr[i] == sr2)) rd_pending[1] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_fwd2;
    logic              w_hit1;
    logic              w_hit2;
    logic [PW-1:0]     w_idx;

    // Walk oldest to youngest so the last match is the youngest pending write.
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = PW'((int'(r_rd_ptr) + k) % DEPTH);
            if (r_q_vld[w_idx] && (r_q_dr[w_idx] == sr1)) begin
                w_hit1 = 1'b1;
                w_fwd1 = r_q_val[w_idx];
            end
            if (r_q_vld[w_idx] && (r_q_dr[w_idx] == sr2)) begin
                w_hit2 = 1'b1;
                w_fwd2 = r_q_val[w_idx];
            end
        end
    end

    assign VSR1 = w_hit1 ? w_fwd1 : w_rf_rd1;
    assign VSR2 = w_hit2 ? w_fwd2 : w_rf_rd2;
`else
    assign VSR1 = w_rf_rd1;
    assign VSR2 = w_rf_rd2;
`endif

    assign psr     = r_psr;
    assign q_count = r_count;
endmodule

// File: tb/tb_wb_queue_regfile.sv
// tb/tb_wb_queue_regfile.sv - randomized and directed bench against a queue-based reference model
module tb_wb_queue_regfile;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int DEPTH    = 2;
    localparam int AW       = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_queue_regfile_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    logic [AW-1:0]     sr1, sr2;
    logic [DATA_W-1:0] VSR1, VSR2;
    logic [1:0]        rd_pending;
    logic              dbg_wr_en;
    logic [AW-1:0]     dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;
    logic [2:0]        psr;
    logic [1:0]        q_count;

    wb_queue_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (bus),
        .sr1         (sr1),
        .sr2         (sr2),
        .VSR1        (VSR1),
        .VSR2        (VSR2),
        .rd_pending  (rd_pending),
        .dbg_wr_en   (dbg_wr_en),
        .dbg_wr_addr (dbg_wr_addr),
        .dbg_wr_data (dbg_wr_data),
        .psr         (psr),
        .q_count     (q_count)
    );

    typedef struct {
        logic [DATA_W-1:0] v;
        logic [AW-1:0]     dr;
        logic              cc;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] mrf [NUM_REGS];
    logic [2:0]        mpsr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DATA_W-1:0] r;
        r = mrf[a];
`ifdef WB_BYPASS_EN
        foreach (mq[i])
            if (mq[i].dr == a) r = mq[i].v;
`endif
        return r;
    endfunction

    function automatic logic pend(input logic [AW-1:0] a);
        foreach (mq[i])
            if (mq[i].dr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] sel_val();
        case (bus.in_sel)
            2'd0:    return bus.aluout;
            2'd1:    return bus.memout;
            2'd2:    return bus.pcout;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NUM_REGS; i++) mrf[i] = '0;
        mpsr = 3'b000;
    endtask

    // Called at a falling edge with inputs already driven: check, clock, advance model.
    task automatic tick();
        ent_t e;
        logic acc;
        #1;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < DEPTH});
        check("q_count", {30'd0, q_count}, mq.size());
        check("psr", {29'd0, psr}, {29'd0, mpsr});
        check("vsr1", {16'd0, VSR1}, {16'd0, exp_rd(sr1)});
        check("vsr2", {16'd0, VSR2}, {16'd0, exp_rd(sr2)});
        check("rd_pending", {30'd0, rd_pending}, {30'd0, pend(sr2), pend(sr1)});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = bus.in_valid && (mq.size() < DEPTH);
            if (dbg_wr_en) begin
                mrf[dbg_wr_addr] = dbg_wr_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                mrf[e.dr] = e.v;
                if (e.cc)
                    mpsr = e.v[DATA_W-1] ? 3'b100 : ((e.v == '0) ? 3'b010 : 3'b001);
            end
            if (acc) begin
                e.v  = sel_val();
                e.dr = bus.in_dr;
                e.cc = bus.in_setcc;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd0;
        bus.aluout   = '0;
        bus.memout   = '0;
        bus.pcout    = '0;
        bus.in_dr    = '0;
        bus.in_setcc = 1'b0;
        dbg_wr_en    = 1'b0;
        dbg_wr_addr  = '0;
        dbg_wr_data  = '0;
    endtask

    task automatic offer(input logic [1:0] sel, input logic [DATA_W-1:0] v,
                         input logic [AW-1:0] dr, input logic cc);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.aluout   = v;
        bus.memout   = v;
        bus.pcout    = v;
        bus.in_dr    = dr;
        bus.in_setcc = cc;
    endtask

    initial begin
        int idx;
        logic rdy;
        logic [DATA_W-1:0] old_r1;

        idle();
        sr1 = '0;
        sr2 = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        tick();
        rst = 1'b0;

        // Reset state: every register reads zero
        for (int a = 0; a < NUM_REGS; a++) begin
            sr1 = AW'(a);
            sr2 = AW'(NUM_REGS - 1 - a);
            tick();
        end
        #1;
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_psr", {29'd0, psr}, 32'd0);

        // Negative ALU result then forced zero
        offer(2'd0, 16'h8000, 3'd3, 1'b1);
        tick();
        idle();
        sr1 = 3'd3;
        tick();
        #1;
        check("alu_rf3", {16'd0, VSR1}, 32'h8000);
        check("alu_psr", {29'd0, psr}, 32'b100);
        offer(2'd3, 16'h1234, 3'd4, 1'b1);
        tick();
        idle();
        sr1 = 3'd4;
        tick();
        #1;
        check("zero_rf4", {16'd0, VSR1}, 32'h0);
        check("zero_psr", {29'd0, psr}, 32'b010);

        // Debug priority fills the queue; release drains in order
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            idle();
            dbg_wr_en   = (c < 3);
            dbg_wr_addr = 3'd7;
            dbg_wr_data = 16'hBEEF;
            if (idx < 3) offer(2'd0, DATA_W'(16'h0100 + idx), AW'(4 + idx), 1'b0);
            rdy = bus.in_ready;
            if (c == 3) begin
                check("full_count", {30'd0, q_count}, 32'd2);
                check("full_ready", {31'd0, rdy}, 32'd0);
            end
            if (c == 4) check("ready_after_drain", {31'd0, rdy}, 32'd1);
            tick();
            if (bus.in_valid && rdy) idx++;
        end
        check("third_accepted", idx, 32'd3);

        // Pending flag and optional forwarding
        idle();
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 3'd1;
        dbg_wr_data = 16'h1234;
        tick();
        idle();
        offer(2'd1, 16'h0005, 3'd1, 1'b0);
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 3'd6;
        dbg_wr_data = 16'h0066;
        tick();
        idle();
        sr1 = 3'd1;
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 3'd6;
        dbg_wr_data = 16'h0066;
        #1;
        check("pending_sr1", {31'd0, rd_pending[0]}, 32'd1);
`ifdef WB_BYPASS_EN
        old_r1 = 16'h0005;
`else
        old_r1 = 16'h1234;
`endif
        check("pending_vsr1", {16'd0, VSR1}, {16'd0, old_r1});
        tick();
        idle();
        tick();
        tick();

        // Drain overwrites a concurrent debug write; then reset discards queued entries
        offer(2'd0, 16'h0011, 3'd2, 1'b1);
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 3'd2;
        dbg_wr_data = 16'h00FF;
        tick();
        idle();
        offer(2'd0, 16'h0022, 3'd2, 1'b1);
        tick();
        idle();
        sr1 = 3'd2;
        tick();
        tick();
        #1;
        check("r2_final", {16'd0, VSR1}, 32'h0022);
        check("r2_psr", {29'd0, psr}, 32'b001);
        offer(2'd0, 16'h8001, 3'd5, 1'b1);
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 3'd2;
        dbg_wr_data = 16'h0022;
        tick();
        offer(2'd0, 16'h0777, 3'd6, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        idle();
        sr1 = 3'd5;
        sr2 = 3'd6;
        #1;
        check("rst_q_count", {30'd0, q_count}, 32'd0);
        check("rst_mid_psr", {29'd0, psr}, 32'd0);
        check("rst_mid_r5", {16'd0, VSR1}, 32'd0);
        tick();
        tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) != 0)
                offer(2'($urandom_range(0, 3)), DATA_W'($urandom), AW'($urandom), 1'($urandom));
            dbg_wr_en   = ($urandom_range(0, 4) == 0);
            dbg_wr_addr = AW'($urandom);
            dbg_wr_data = DATA_W'($urandom);
            sr1 = AW'($urandom);
            sr2 = AW'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
